// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: geometry, FSM states and
// address field helpers.
package cache_miss_ctrl_pkg;

  localparam int NUM_SETS   = 32;
  localparam int NUM_WAYS   = 4;
  localparam int IDX_W      = 5;
  localparam int WAY_W      = 2;
  localparam int MAX_ADDR_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    REFILL_REQ,
    REFILL_WAIT,
    RESP
  } state_e;

  // Helpers take a zero-extended address so they work for any ADDR_W.
  function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int offs_w);
    return addr >> (offs_w + IDX_W);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                  input int offs_w);
    logic [MAX_ADDR_W-1:0] shifted;
    shifted = addr >> offs_w;
    return shifted[IDX_W-1:0];
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] addr_offset(input logic [MAX_ADDR_W-1:0] addr,
                                                        input int offs_w);
    return addr & ((MAX_ADDR_W'(1) << offs_w) - MAX_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_repl_ptr_table.sv
// Per-set 2-bit FIFO replacement pointers; the addressed pointer advances
// (mod 4) when a full set evicts a line.
module repl_ptr_table
  import cache_miss_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] index,
  input  logic             advance,
  output logic [WAY_W-1:0] ptr
);

  logic [WAY_W-1:0] ptr_reg [NUM_SETS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) ptr_reg[s] <= '0;
    end else if (advance) begin
      ptr_reg[index] <= ptr_reg[index] + 1'b1;
    end
  end

  assign ptr = ptr_reg[index];

endmodule

// File: rtl/cache_miss_ctrl.sv
// 4-way, 32-set cache miss controller with FIFO replacement.
// Define CACHE_MISS_CTRL_WRITEBACK_EN to add dirty tracking and victim writeback.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int OFFS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  output logic [WAY_W-1:0]  way_sel,
  output logic [IDX_W-1:0]  set_sel,
  output logic              line_we,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid
);

  localparam int TAG_W = ADDR_W - OFFS_W - IDX_W;

  state_e state_reg, state_next;

  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WAY_W-1:0]  way_reg;
  logic              hit_reg;
  logic [TAG_W-1:0]  victim_tag_reg;

  logic [TAG_W-1:0]    tag_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_reg [NUM_SETS];

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [NUM_WAYS-1:0] set_valid;
  logic [NUM_WAYS-1:0] way_match;
  logic                lookup_hit;
  logic                all_valid;
  logic                victim_dirty;
  logic [WAY_W-1:0]    hit_way, victim_way, lookup_way, fifo_ptr;
  logic [ADDR_W-1:0]   line_addr, wb_addr;
  logic                refill_done;

  assign req_idx   = addr_index(MAX_ADDR_W'(addr_reg), OFFS_W);
  assign req_tag   = TAG_W'(addr_tag(MAX_ADDR_W'(addr_reg), OFFS_W));
  assign set_valid = valid_reg[req_idx];
  assign line_addr = {addr_reg[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  assign wb_addr   = {victim_tag_reg, req_idx, {OFFS_W{1'b0}}};
  assign refill_done = (state_reg == REFILL_WAIT) && mem_resp_valid;

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_cmp
      assign way_match[gi] = set_valid[gi] && (tag_mem[req_idx][gi] == req_tag);
    end
  endgenerate

  // Descending scans leave the lowest-numbered matching/invalid way selected.
  always_comb begin
    hit_way    = '0;
    victim_way = fifo_ptr;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_match[w])  hit_way    = WAY_W'(w);
      if (!set_valid[w]) victim_way = WAY_W'(w);
    end
  end

  assign lookup_hit = |way_match;
  assign all_valid  = &set_valid;
  assign lookup_way = lookup_hit ? hit_way : victim_way;

  repl_ptr_table u_repl_ptr_table (
    .clk     (clk),
    .reset   (reset),
    .index   (req_idx),
    .advance ((state_reg == LOOKUP) && !lookup_hit && all_valid),
    .ptr     (fifo_ptr)
  );

`ifdef CACHE_MISS_CTRL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
  logic [NUM_WAYS-1:0] dirty_reg [NUM_SETS];

  assign victim_dirty = set_valid[victim_way] && dirty_reg[req_idx][victim_way];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) dirty_reg[s] <= '0;
    end else if ((state_reg == LOOKUP) && lookup_hit && we_reg) begin
      dirty_reg[req_idx][hit_way] <= 1'b1;
    end else if (refill_done) begin
      dirty_reg[req_idx][way_reg] <= we_reg;
    end
  end
`else
  localparam bit WB_EN = 1'b0;
  assign victim_dirty = 1'b0;
`endif

  // Tags carry no reset; a way's tag is only trusted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (refill_done) tag_mem[req_idx][way_reg] <= req_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) valid_reg[s] <= '0;
    end else if (refill_done) begin
      valid_reg[req_idx][way_reg] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      way_reg        <= '0;
      hit_reg        <= 1'b0;
      victim_tag_reg <= '0;
    end else begin
      if (state_reg == IDLE && cpu_req_valid) begin
        we_reg   <= cpu_req_we;
        addr_reg <= cpu_req_addr;
      end
      if (state_reg == LOOKUP) begin
        way_reg        <= lookup_way;
        hit_reg        <= lookup_hit;
        victim_tag_reg <= tag_mem[req_idx][victim_way];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:        if (cpu_req_valid && cpu_req_ready) state_next = LOOKUP;
      LOOKUP: begin
        if (lookup_hit)        state_next = RESP;
        else if (victim_dirty) state_next = WB;
        else                   state_next = REFILL_REQ;
      end
      WB:          if (mem_req_ready)  state_next = REFILL_REQ;
      REFILL_REQ:  if (mem_req_ready)  state_next = REFILL_WAIT;
      REFILL_WAIT: if (mem_resp_valid) state_next = RESP;
      RESP:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Outputs are gated by reset so that every output reads 0 while it is held.
  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_hit   = 1'b0;
    line_we        = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    way_sel        = way_reg;
    set_sel        = req_idx;
    if (reset) begin
      way_sel = '0;
      set_sel = '0;
    end else begin
      case (state_reg)
        IDLE:   cpu_req_ready = 1'b1;
        LOOKUP: way_sel = lookup_way;
        WB: begin
          mem_req_valid = 1'b1;
          mem_req_we    = WB_EN;
          mem_req_addr  = wb_addr;
        end
        REFILL_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = line_addr;
        end
        REFILL_WAIT: line_we = mem_resp_valid;
        RESP: begin
          cpu_resp_valid = 1'b1;
          cpu_resp_hit   = hit_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl; WB expectations follow
// CACHE_MISS_CTRL_WRITEBACK_EN.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_req_we = 1'b0;
  logic [15:0] cpu_req_addr = '0;
  logic        cpu_resp_valid;
  logic        cpu_resp_hit;
  logic [1:0]  way_sel;
  logic [4:0]  set_sel;
  logic        line_we;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [15:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        hit;
    logic [1:0]  way;
    logic [4:0]  set;
    int          lat;
    int          wb_cnt;
    logic [15:0] wb_addr;
    logic        wb_first;
    int          rf_cnt;
    logic [15:0] rf_addr;
    int          lwe_cnt;
    logic        resp_extra;
    logic        done;
  } res_t;

  always #5 clk = ~clk;

  cache_miss_ctrl #(.ADDR_W(16), .OFFS_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_hit   (cpu_resp_hit),
    .way_sel        (way_sel),
    .set_sel        (set_sel),
    .line_we        (line_we),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one CPU access from idle and plays an always-ready memory that answers
  // a refill one cycle after its handshake.
  task automatic access(input logic we, input logic [15:0] addr, output res_t r);
    bit give_resp;
    give_resp = 1'b0;
    r = '{default: 0};
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      cpu_req_valid  = 1'b0;
      mem_resp_valid = give_resp;
      give_resp      = 1'b0;
      mem_req_ready  = 1'b0;
      #1;
      if (line_we) r.lwe_cnt++;
      if (cpu_resp_valid) begin
        r.hit  = cpu_resp_hit;
        r.way  = way_sel;
        r.set  = set_sel;
        r.lat  = i;
        r.done = 1'b1;
        break;
      end
      if (mem_req_valid) begin
        if (mem_req_we) begin
          r.wb_cnt++;
          r.wb_addr = mem_req_addr;
          if (r.rf_cnt == 0) r.wb_first = 1'b1;
        end else begin
          r.rf_cnt++;
          r.rf_addr = mem_req_addr;
          give_resp = 1'b1;
        end
        mem_req_ready = 1'b1;
      end
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    #1;
    r.resp_extra = cpu_resp_valid;
    $display("access we=%0b addr=%h hit=%0b way=%0d set=%0d lat=%0d wb=%0d rf=%0d rf_addr=%h",
             we, addr, r.hit, r.way, r.set, r.lat, r.wb_cnt, r.rf_cnt, r.rf_addr);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({cpu_req_ready, cpu_resp_valid, cpu_resp_hit, line_we, mem_req_valid, mem_req_we} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl_outputs: got %b want 000000",
               {cpu_req_ready, cpu_resp_valid, cpu_resp_hit, line_we, mem_req_valid, mem_req_we});
    end
    n_cmp++;
    if ({way_sel, set_sel, mem_req_addr} !== 23'b0) begin
      n_bad++;
      $display("FAIL reset_bus_outputs: way=%0d set=%0d addr=%h want 0", way_sel, set_sel, mem_req_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cpu_req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b want 1", cpu_req_ready);
    end
    $display("reset released, cpu_req_ready=%b", cpu_req_ready);
  endtask

  task automatic test_miss_then_hit();
    res_t r;
    access(1'b0, 16'h1230, r);
    n_cmp++;
    if (r.done !== 1'b1) begin n_bad++; $display("FAIL miss1_timeout: no response"); end
    n_cmp++;
    if ({r.hit, r.way, r.set} !== {1'b0, 2'd0, 5'd3}) begin
      n_bad++;
      $display("FAIL miss1_resp: hit=%b way=%0d set=%0d want hit=0 way=0 set=3", r.hit, r.way, r.set);
    end
    n_cmp++;
    if (r.rf_cnt !== 1 || r.rf_addr !== 16'h1230 || r.wb_cnt !== 0) begin
      n_bad++;
      $display("FAIL miss1_memreq: rf=%0d addr=%h wb=%0d want rf=1 addr=1230 wb=0", r.rf_cnt, r.rf_addr, r.wb_cnt);
    end
    n_cmp++;
    if (r.lat !== 4 || r.lwe_cnt !== 1 || r.resp_extra !== 1'b0) begin
      n_bad++;
      $display("FAIL miss1_timing: lat=%0d line_we=%0d extra=%b want 4 1 0", r.lat, r.lwe_cnt, r.resp_extra);
    end
    access(1'b0, 16'h1230, r);
    n_cmp++;
    if ({r.hit, r.way} !== {1'b1, 2'd0} || r.lat !== 2) begin
      n_bad++;
      $display("FAIL hit1: hit=%b way=%0d lat=%0d want hit=1 way=0 lat=2", r.hit, r.way, r.lat);
    end
    n_cmp++;
    if (r.rf_cnt !== 0 || r.lwe_cnt !== 0 || r.resp_extra !== 1'b0) begin
      n_bad++;
      $display("FAIL hit1_side: rf=%0d line_we=%0d extra=%b want 0 0 0", r.rf_cnt, r.lwe_cnt, r.resp_extra);
    end
  endtask

  task automatic test_fifo_replacement();
    res_t r;
    logic [15:0] addrs [6];
    logic [1:0]  ways  [6];
    addrs = '{16'h0230, 16'h0430, 16'h0630, 16'h0830, 16'h0A3C, 16'h0C30};
    ways  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      access(1'b0, addrs[i], r);
      n_cmp++;
      if ({r.hit, r.way, r.set} !== {1'b0, ways[i], 5'd3} ||
          r.rf_addr !== {addrs[i][15:4], 4'h0}) begin
        n_bad++;
        $display("FAIL fifo_victim[%0d]: hit=%b way=%0d set=%0d rf_addr=%h want hit=0 way=%0d set=3 rf_addr=%h",
                 i, r.hit, r.way, r.set, r.rf_addr, ways[i], {addrs[i][15:4], 4'h0});
      end
    end
    access(1'b0, 16'h0630, r);
    n_cmp++;
    if ({r.hit, r.way} !== {1'b1, 2'd2}) begin
      n_bad++;
      $display("FAIL fifo_survivor: hit=%b way=%0d want hit=1 way=2", r.hit, r.way);
    end
    access(1'b0, 16'h0230, r);
    n_cmp++;
    if ({r.hit, r.way} !== {1'b0, 2'd2}) begin
      n_bad++;
      $display("FAIL fifo_evicted: hit=%b way=%0d want hit=0 way=2", r.hit, r.way);
    end
  endtask

  task automatic test_writeback();
    res_t r;
    do_reset();
    access(1'b0, 16'h0050, r);
    access(1'b1, 16'h0054, r);
    n_cmp++;
    if ({r.hit, r.way} !== {1'b1, 2'd0} || r.lat !== 2) begin
      n_bad++;
      $display("FAIL write_hit: hit=%b way=%0d lat=%0d want hit=1 way=0 lat=2", r.hit, r.way, r.lat);
    end
    access(1'b0, 16'h0250, r);
    access(1'b0, 16'h0450, r);
    access(1'b0, 16'h0650, r);
    access(1'b0, 16'h0850, r);
    n_cmp++;
    if ({r.hit, r.way} !== {1'b0, 2'd0} || r.rf_addr !== 16'h0850 || r.rf_cnt !== 1) begin
      n_bad++;
      $display("FAIL evict_refill: hit=%b way=%0d rf_addr=%h rf=%0d want hit=0 way=0 rf_addr=0850 rf=1",
               r.hit, r.way, r.rf_addr, r.rf_cnt);
    end
`ifdef CACHE_MISS_CTRL_WRITEBACK_EN
    n_cmp++;
    if (r.wb_cnt !== 1 || r.wb_addr !== 16'h0050 || r.wb_first !== 1'b1) begin
      n_bad++;
      $display("FAIL evict_wb: wb=%0d addr=%h first=%b want wb=1 addr=0050 first=1",
               r.wb_cnt, r.wb_addr, r.wb_first);
    end
`else
    n_cmp++;
    if (r.wb_cnt !== 0) begin
      n_bad++;
      $display("FAIL evict_no_wb: wb=%0d want 0", r.wb_cnt);
    end
`endif
  endtask

  task automatic test_mem_stall();
    do_reset();
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 16'h1457;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({mem_req_valid, mem_req_we, mem_req_addr, cpu_resp_valid} !== {1'b1, 1'b0, 16'h1450, 1'b0}) begin
        n_bad++;
        $display("FAIL stall[%0d]: valid=%b we=%b addr=%h resp=%b want 1 0 1450 0",
                 k, mem_req_valid, mem_req_we, mem_req_addr, cpu_resp_valid);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    n_cmp++;
    if ({line_we, mem_req_valid, cpu_resp_valid, way_sel, set_sel} !== {1'b1, 1'b0, 1'b0, 2'd0, 5'd5}) begin
      n_bad++;
      $display("FAIL stall_refill: line_we=%b mreq=%b resp=%b way=%0d set=%0d want 1 0 0 0 5",
               line_we, mem_req_valid, cpu_resp_valid, way_sel, set_sel);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_resp_valid, cpu_resp_hit} !== 2'b10) begin
      n_bad++;
      $display("FAIL stall_resp: valid=%b hit=%b want 1 0", cpu_resp_valid, cpu_resp_hit);
    end
    @(negedge clk);
    #1;
    $display("stall transaction done, ready=%b", cpu_req_ready);
  endtask

  task automatic test_reset_mid_refill();
    res_t r;
    do_reset();
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 16'h2470;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cpu_req_ready, cpu_resp_valid, line_we, mem_req_valid, way_sel, set_sel} !== 11'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: rdy=%b resp=%b lwe=%b mreq=%b way=%0d set=%0d want all 0",
               cpu_req_ready, cpu_resp_valid, line_we, mem_req_valid, way_sel, set_sel);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    #1;
    n_cmp++;
    if ({line_we, cpu_req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL late_resp: line_we=%b ready=%b want 0 1", line_we, cpu_req_ready);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (cpu_resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL late_resp_noresp: resp=%b want 0", cpu_resp_valid);
    end
    access(1'b0, 16'h2470, r);
    n_cmp++;
    if (r.hit !== 1'b0 || r.rf_cnt !== 1) begin
      n_bad++;
      $display("FAIL after_midreset: hit=%b rf=%0d want hit=0 rf=1", r.hit, r.rf_cnt);
    end
  endtask

  task automatic test_spurious_resp();
    res_t r;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    #1;
    n_cmp++;
    if ({line_we, cpu_req_ready, mem_req_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL idle_pulse: line_we=%b ready=%b mreq=%b want 0 1 0", line_we, cpu_req_ready, mem_req_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_resp_valid, cpu_req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL idle_pulse_after: resp=%b ready=%b want 0 1", cpu_resp_valid, cpu_req_ready);
    end
    access(1'b0, 16'h2470, r);
    n_cmp++;
    if ({r.hit, r.way} !== {1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL idle_pulse_hit: hit=%b way=%0d want hit=1 way=0", r.hit, r.way);
    end
    access(1'b0, 16'h2670, r);
    n_cmp++;
    if ({r.hit, r.way, r.set} !== {1'b0, 2'd1, 5'd7}) begin
      n_bad++;
      $display("FAIL idle_pulse_neighbour: hit=%b way=%0d set=%0d want hit=0 way=1 set=7", r.hit, r.way, r.set);
    end
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_fifo_replacement();
    test_writeback();
    test_mem_stall();
    test_reset_mid_refill();
    test_spurious_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
